// File: rtl/rk_sram_pkg.sv
// Shared types and constants for the external 16-bit SRAM arbiter.
package rk_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester IDs double as bit positions in the one-hot grant vector.
  typedef enum logic [1:0] {
    REQ_VID = 2'd0,
    REQ_CPU = 2'd1,
    REQ_LDR = 2'd2
  } req_id_t;

  localparam int ACC_CYC_DEF = 2;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/rk_sram_arb_if.sv
// Requester ports and SRAM pins of the arbiter; slave = arbiter side.
interface rk_sram_arb_if #(parameter int ADDR_W = 18);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [15:0]       vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W:0]   cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              ldr_req;
  logic [ADDR_W:0]   ldr_addr;
  logic [7:0]        ldr_wdata;
  logic              ldr_ack;

  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_i;
  logic [15:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           ldr_req, ldr_addr, ldr_wdata, sram_dq_i,
    output vid_ack, vid_rdata, cpu_ack, cpu_rdata, ldr_ack,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n,
           sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           ldr_req, ldr_addr, ldr_wdata, sram_dq_i,
    input  vid_ack, vid_rdata, cpu_ack, cpu_rdata, ldr_ack,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n,
           sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/rk_sram_prio.sv
// Priority picker (vid > cpu > ldr) with a counter that hands the CPU
// a grant after VID_BURST consecutive video grants it sat through.
module rk_sram_prio
  import rk_sram_pkg::*;
#(
  parameter int VID_BURST = 2
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       grant_en,
  input  logic       vid_req,
  input  logic       cpu_req,
  input  logic       ldr_req,
  output logic [2:0] gnt
);

  localparam int BW = $clog2(VID_BURST + 1);

  logic [BW-1:0] burst_q;
  logic [BW-1:0] burst_d;
  logic          cpu_turn;

  // Grant selection and starvation counter next-state.
  always_comb begin
    cpu_turn = cpu_req && (burst_q >= BW'(VID_BURST));
    gnt      = 3'b000;
    if (!grant_en) begin
      gnt = 3'b000;
    end else if (cpu_turn) begin
      gnt[REQ_CPU] = 1'b1;
    end else if (vid_req) begin
      gnt[REQ_VID] = 1'b1;
    end else if (cpu_req) begin
      gnt[REQ_CPU] = 1'b1;
    end else if (ldr_req) begin
      gnt[REQ_LDR] = 1'b1;
    end else begin
      gnt = 3'b000;
    end

    if (!cpu_req) begin
      burst_d = BW'(0);
    end else if (gnt[REQ_CPU]) begin
      burst_d = BW'(0);
    end else if (gnt[REQ_VID] && (burst_q < BW'(VID_BURST))) begin
      burst_d = burst_q + BW'(1);
    end else begin
      burst_d = burst_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      burst_q <= BW'(0);
    end else begin
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/rk_sram_arb.sv
// Registered, cycle-exact access sequencer sharing one async 16-bit SRAM
// between video fetch, CPU and SD loader.
module rk_sram_arb
  import rk_sram_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int ACC_CYC   = ACC_CYC_DEF,
  parameter int VID_BURST = 2
) (
  input  logic        clk50,
  input  logic        reset,
  rk_sram_arb_if.slave bus
);

  localparam int CW = $clog2(ACC_CYC);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  req_id_t           id_q, id_d;
  logic              we_q, we_d;
  logic              lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              vid_ack_q, vid_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [15:0]       vid_rdata_q, vid_rdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              grant_en;
  logic [2:0]        gnt;

  assign grant_en = (state_q == IDLE) || (state_q == DONE);

  rk_sram_prio #(.VID_BURST(VID_BURST)) u_prio (
    .clk50    (clk50),
    .reset    (reset),
    .grant_en (grant_en),
    .vid_req  (bus.vid_req),
    .cpu_req  (bus.cpu_req),
    .ldr_req  (bus.ldr_req),
    .gnt      (gnt)
  );

  // Next-state and next-pin values; every pin is driven from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    we_d        = we_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (gnt != 3'b000) begin
          state_d = ACCESS;
          cnt_d   = CW'(0);
          if (gnt[REQ_VID]) begin
            id_d   = REQ_VID;
            we_d   = 1'b0;
            lane_d = LANE_LO;
            addr_d = bus.vid_addr;
          end else if (gnt[REQ_CPU]) begin
            id_d   = REQ_CPU;
            we_d   = bus.cpu_we;
            lane_d = bus.cpu_addr[0];
            addr_d = bus.cpu_addr[ADDR_W:1];
            dq_o_d = {bus.cpu_wdata, bus.cpu_wdata};
          end else begin
            id_d   = REQ_LDR;
            we_d   = 1'b1;
            lane_d = bus.ldr_addr[0];
            addr_d = bus.ldr_addr[ADDR_W:1];
            dq_o_d = {bus.ldr_wdata, bus.ldr_wdata};
          end
          ce_n_d  = 1'b0;
          oe_n_d  = we_d;
          we_n_d  = 1'b1;
          dq_oe_d = we_d;
          // Video always reads the full word; byte accesses strobe one lane.
          ub_n_d  = !((id_d == REQ_VID) || (lane_d == LANE_HI));
          lb_n_d  = !((id_d == REQ_VID) || (lane_d == LANE_LO));
        end else begin
          state_d = IDLE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          dq_oe_d = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q == CW'(ACC_CYC - 1)) begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          dq_oe_d = we_q;
          case (id_q)
            REQ_VID: begin
              vid_ack_d   = 1'b1;
              vid_rdata_d = bus.sram_dq_i;
            end
            REQ_CPU: begin
              cpu_ack_d = 1'b1;
              if (!we_q) begin
                cpu_rdata_d = lane_byte(bus.sram_dq_i, lane_q);
              end else begin
                cpu_rdata_d = cpu_rdata_q;
              end
            end
            REQ_LDR: begin
              ldr_ack_d = 1'b1;
            end
            default: begin
              ldr_ack_d = 1'b0;
            end
          endcase
        end else begin
          cnt_d  = cnt_q + CW'(1);
          // Count 0 is address/data setup; the write strobe follows it.
          we_n_d = !we_q;
        end
      end
      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the SRAM immediately.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= CW'(0);
      id_q        <= REQ_VID;
      we_q        <= 1'b0;
      lane_q      <= 1'b0;
      addr_q      <= ADDR_W'(0);
      dq_o_q      <= 16'h0000;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      vid_rdata_q <= 16'h0000;
      cpu_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_ub_n  = ub_n_q;
  assign bus.sram_lb_n  = lb_n_q;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.ldr_ack    = ldr_ack_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_rk_sram_arb.sv
// Scoreboard bench for rk_sram_arb: SRAM device model, word/byte memory
// reference, per-requester expectation queues drained by an ack monitor.
module tb_rk_sram_arb;

  localparam int ADDR_W = 18;

  logic clk50 = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  rk_sram_arb_if #(.ADDR_W(ADDR_W)) bus ();

  rk_sram_arb #(.ADDR_W(ADDR_W), .ACC_CYC(2), .VID_BURST(2)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Background memory contents, shared by the device model and the reference.
  function automatic logic [15:0] pat(input int w);
    return 16'((w * 40503) ^ 23235 ^ (w >> 7));
  endfunction

  logic [15:0] sram_m [int];
  logic [15:0] ref_w  [int];
  logic [15:0] mw;

  function automatic logic [15:0] sram_rd(input int w);
    return sram_m.exists(w) ? sram_m[w] : pat(w);
  endfunction

  function automatic logic [15:0] ref_word(input int w);
    return ref_w.exists(w) ? ref_w[w] : pat(w);
  endfunction

  function automatic logic [7:0] ref_byte(input int b);
    logic [15:0] x;
    x = ref_word(b >> 1);
    return b[0] ? x[15:8] : x[7:0];
  endfunction

  task automatic ref_wr(input int b, input logic [7:0] d);
    logic [15:0] x;
    x = ref_word(b >> 1);
    if (b[0]) x[15:8] = d;
    else      x[7:0]  = d;
    ref_w[b >> 1] = x;
  endtask

  task automatic preload(input int w, input logic [15:0] v);
    sram_m[w] = v;
    ref_w[w]  = v;
  endtask

  // Asynchronous SRAM device: commits lane writes, drives data when enabled.
  always @(negedge clk50) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) begin
      mw = sram_rd(int'(bus.sram_addr));
      if (!bus.sram_lb_n) mw[7:0]  = bus.sram_dq_o[7:0];
      if (!bus.sram_ub_n) mw[15:8] = bus.sram_dq_o[15:8];
      sram_m[int'(bus.sram_addr)] = mw;
    end
    bus.sram_dq_i <= (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_rd(int'(bus.sram_addr)) : 16'hDEAD;
  end

  typedef struct { bit rd; logic [7:0] d; } cpu_exp_t;
  typedef struct { int id; int c; } ack_t;

  logic [15:0] q_vid [$];
  cpu_exp_t    q_cpu [$];
  int          ldr_pending = 0;
  ack_t        ack_log [$];
  cpu_exp_t    ce;

  task automatic vid_issue(input int w);
    q_vid.push_back(ref_word(w));
    bus.vid_addr = 18'(w);
    bus.vid_req  = 1'b1;
  endtask

  task automatic cpu_issue(input bit we, input int b, input logic [7:0] d);
    cpu_exp_t e;
    e.rd = !we;
    e.d  = ref_byte(b);
    if (we) ref_wr(b, d);
    q_cpu.push_back(e);
    bus.cpu_we    = we;
    bus.cpu_addr  = 19'(b);
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
  endtask

  task automatic ldr_issue(input int b, input logic [7:0] d);
    ref_wr(b, d);
    ldr_pending++;
    bus.ldr_addr  = 19'(b);
    bus.ldr_wdata = d;
    bus.ldr_req   = 1'b1;
  endtask

  task automatic wait_ack(input int id, output int n);
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk50);
      if ((id == 0 && bus.vid_ack) || (id == 1 && bus.cpu_ack) || (id == 2 && bus.ldr_ack)) begin
        n = i;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL ack_timeout: requester %0d saw no ack within 2000 cycles", id);
  endtask

  // Monitor: pops an expectation for every ack and logs grant order.
  always @(negedge clk50) begin
    if (!reset) begin
      if (!bus.sram_ce_n) chk("oe_we_exclusive", {bus.sram_oe_n, bus.sram_we_n} == 2'b00, 1'b0);
      if (bus.vid_ack || bus.cpu_ack || bus.ldr_ack)
        chk("ack_onehot", 2'(bus.vid_ack) + 2'(bus.cpu_ack) + 2'(bus.ldr_ack), 2'd1);
      if (bus.vid_ack) begin
        ack_log.push_back('{0, cyc});
        total++;
        if (q_vid.size() == 0) begin
          bad++;
          $display("FAIL vid_ack: unexpected ack, rdata %0h", bus.vid_rdata);
        end else begin
          total--;
          chk("vid_rdata", bus.vid_rdata, q_vid.pop_front());
        end
      end
      if (bus.cpu_ack) begin
        ack_log.push_back('{1, cyc});
        total++;
        if (q_cpu.size() == 0) begin
          bad++;
          $display("FAIL cpu_ack: unexpected ack, rdata %0h", bus.cpu_rdata);
        end else begin
          total--;
          ce = q_cpu.pop_front();
          if (ce.rd) chk("cpu_rdata", bus.cpu_rdata, ce.d);
        end
      end
      if (bus.ldr_ack) begin
        ack_log.push_back('{2, cyc});
        chk("ldr_ack_expected", ldr_pending > 0, 1'b1);
        if (ldr_pending > 0) ldr_pending--;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nv, nc, base, t0, b, w;
    int ldr_addrs [$];
    int exp_ids [7] = '{0, 0, 1, 0, 0, 1, 0};
    logic [15:0] tmp;

    reset = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    repeat (3) @(negedge clk50);
    chk("reset_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 6'b111110);
    chk("reset_addr_dq", {bus.sram_addr, bus.sram_dq_o}, 34'h0);
    chk("reset_acks_rdata", {bus.vid_ack, bus.cpu_ack, bus.ldr_ack, bus.vid_rdata, bus.cpu_rdata}, 27'h0);
    reset = 1'b0;
    @(negedge clk50);

    // CPU read, upper lane.
    preload(18'h00091, 16'hA55A);
    cpu_issue(1'b0, 32'h123, 8'h00);
    @(negedge clk50);
    chk("rd_c0_addr", bus.sram_addr, 18'h00091);
    chk("rd_c0_pins", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 6'b001010);
    @(negedge clk50);
    chk("rd_c1_pins", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'b00101);
    @(negedge clk50);
    chk("rd_c2_ack", {bus.cpu_ack, bus.sram_oe_n}, 2'b11);
    bus.cpu_req = 1'b0;
    @(negedge clk50);
    chk("rd_c3_hold", {bus.cpu_ack, bus.cpu_rdata}, 9'h0A5);

    // CPU write, lower lane.
    cpu_issue(1'b1, 32'h200, 8'h3C);
    @(negedge clk50);
    chk("wr_c0_pins", {bus.sram_we_n, bus.sram_dq_oe, bus.sram_ub_n, bus.sram_lb_n, bus.sram_oe_n}, 5'b11101);
    chk("wr_c0_dq", bus.sram_dq_o, 16'h3C3C);
    @(negedge clk50);
    chk("wr_c1_we", {bus.sram_we_n, bus.sram_dq_oe, bus.sram_ub_n, bus.sram_lb_n}, 4'b0110);
    @(negedge clk50);
    chk("wr_c2_hold", {bus.sram_we_n, bus.sram_dq_oe, bus.cpu_ack, bus.sram_addr}, {3'b111, 18'h00100});
    bus.cpu_req = 1'b0;
    tmp = sram_rd(32'h100);
    chk("wr_mem_lo", tmp[7:0], 8'h3C);
    @(negedge clk50);
    chk("wr_c3_release", bus.sram_dq_oe, 1'b0);

    // Video word read.
    preload(18'h0ABCD, 16'h1234);
    vid_issue(32'h0ABCD);
    @(negedge clk50);
    chk("vid_c0_pins", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'b00100);
    @(negedge clk50);
    chk("vid_c1_we", bus.sram_we_n, 1'b1);
    @(negedge clk50);
    chk("vid_c2_ack", {bus.vid_ack, bus.sram_we_n}, 2'b11);
    bus.vid_req = 1'b0;
    @(negedge clk50);

    // Video and CPU held continuously: vid, vid, cpu, ...
    base = ack_log.size();
    for (int k = 0; k < 5; k++) q_vid.push_back(16'h1234);
    for (int k = 0; k < 2; k++) q_cpu.push_back('{1'b1, 8'hA5});
    bus.vid_addr = 18'h0ABCD; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h123;
    bus.vid_req = 1'b1; bus.cpu_req = 1'b1;
    nv = 0; nc = 0;
    for (int i = 0; i < 80 && !(nv == 5 && nc == 2); i++) begin
      @(negedge clk50);
      if (bus.cpu_ack) begin nc++; if (nc == 2) bus.cpu_req = 1'b0; end
      if (bus.vid_ack) begin nv++; if (nv == 5) bus.vid_req = 1'b0; end
    end
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk50);
    chk("burst_ack_count", ack_log.size() - base, 7);
    if (ack_log.size() - base == 7) begin
      for (int k = 0; k < 7; k++) chk($sformatf("burst_order_%0d", k), ack_log[base + k].id, exp_ids[k]);
      for (int k = 1; k < 7; k++) chk($sformatf("burst_spacing_%0d", k), ack_log[base + k].c - ack_log[base + k - 1].c, 3);
    end

    // CPU and loader together: CPU first, loader three cycles later.
    base = ack_log.size();
    t0 = cyc;
    cpu_issue(1'b0, 32'h123, 8'h00);
    ldr_issue(32'h201, 8'h77);
    nc = 0; nv = 0;
    for (int i = 0; i < 40 && !(nc == 1 && nv == 1); i++) begin
      @(negedge clk50);
      if (bus.cpu_ack) begin nc = 1; bus.cpu_req = 1'b0; end
      if (bus.ldr_ack) begin nv = 1; bus.ldr_req = 1'b0; end
    end
    @(negedge clk50);
    chk("cl_ack_count", ack_log.size() - base, 2);
    if (ack_log.size() - base == 2) begin
      chk("cl_first_cpu", ack_log[base].id, 1);
      chk("cl_cpu_latency", ack_log[base].c - t0, 3);
      chk("cl_second_ldr", ack_log[base + 1].id, 2);
      chk("cl_ldr_latency", ack_log[base + 1].c - t0, 6);
    end

    // Randomised concurrent traffic on disjoint regions.
    fork
      begin
        int vw, vn;
        for (int i = 0; i < 40; i++) begin
          vw = 32'h10000 + int'($urandom_range(0, 32'hFFFF));
          vid_issue(vw);
          wait_ack(0, vn);
          bus.vid_req = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk50);
        end
      end
      begin
        int cb, cn;
        for (int i = 0; i < 40; i++) begin
          cb = int'($urandom_range(0, 32'h1FF));
          cpu_issue(1'($urandom_range(0, 1)), cb, 8'($urandom));
          wait_ack(1, cn);
          bus.cpu_req = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk50);
        end
      end
      begin
        int lb, ln;
        for (int i = 0; i < 30; i++) begin
          lb = 32'h200 + int'($urandom_range(0, 32'h1FF));
          ldr_addrs.push_back(lb);
          ldr_issue(lb, 8'($urandom));
          wait_ack(2, ln);
          bus.ldr_req = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk50);
        end
      end
    join

    // CPU reads back what the loader wrote.
    ldr_addrs.push_back(32'h200);
    ldr_addrs.push_back(32'h201);
    foreach (ldr_addrs[k]) begin
      b = ldr_addrs[k];
      cpu_issue(1'b0, b, 8'h00);
      wait_ack(1, n);
      bus.cpu_req = 1'b0;
    end

    // Reset during the write strobe.
    @(negedge clk50);
    cpu_issue(1'b1, 32'h205, 8'h99);
    @(negedge clk50);
    chk("rst_c0_we_n", bus.sram_we_n, 1'b1);
    @(negedge clk50);
    chk("rst_c1_we_n", bus.sram_we_n, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_release", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 6'b111110);
    chk("rst_no_ack", {bus.vid_ack, bus.cpu_ack, bus.ldr_ack}, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk50);
      chk("rst_held_idle", {bus.cpu_ack, bus.sram_ce_n}, 2'b01);
    end
    reset = 1'b0;
    wait_ack(1, n);
    chk("rst_after_latency", n, 3);
    bus.cpu_req = 1'b0;
    w = 32'h205;
    cpu_issue(1'b0, w, 8'h00);
    wait_ack(1, n);
    bus.cpu_req = 1'b0;

    repeat (3) @(negedge clk50);
    chk("queues_drained", q_vid.size() + q_cpu.size() + ldr_pending, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
